// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C transaction sequencer: master register bits, error codes,
// FSM state encodings and the per-phase TXR/CR selection helpers.
package i2c_seq_pkg;

    localparam logic [7:0] CrSta  = 8'h80;
    localparam logic [7:0] CrSto  = 8'h40;
    localparam logic [7:0] CrRd   = 8'h20;
    localparam logic [7:0] CrWr   = 8'h10;
    localparam logic [7:0] CrNack = 8'h08;

    localparam int unsigned SrRxAck = 7;
    localparam int unsigned SrAl    = 5;
    localparam int unsigned SrTip   = 1;

    localparam logic [7:0] CtrEn = 8'h80;

    localparam logic [1:0] ErrOk   = 2'b00;
    localparam logic [1:0] ErrNack = 2'b01;
    localparam logic [1:0] ErrAl   = 2'b10;
    localparam logic [1:0] ErrTmo  = 2'b11;

    localparam logic [3:0] StInitPrer  = 4'd0;
    localparam logic [3:0] StInitCtr   = 4'd1;
    localparam logic [3:0] StIdle      = 4'd2;
    localparam logic [3:0] StIssue     = 4'd3;
    localparam logic [3:0] StPoll      = 4'd4;
    localparam logic [3:0] StCheck     = 4'd5;
    localparam logic [3:0] StAbortStop = 4'd6;
    localparam logic [3:0] StAbortPoll = 4'd7;
    localparam logic [3:0] StResp      = 4'd8;

    function automatic logic [7:0] phase_cr(input logic rw, input logic [1:0] phase);
        case (phase)
            2'd0:    return CrSta | CrWr;
            2'd1:    return CrWr;
            2'd2:    return rw ? (CrSta | CrWr) : (CrSto | CrWr);
            default: return CrRd | CrNack | CrSto;
        endcase
    endfunction

    function automatic logic [7:0] phase_txr(input logic rw, input logic [1:0] phase,
                                             input logic [6:0] sadr, input logic [7:0] madr,
                                             input logic [7:0] wdata);
        case (phase)
            2'd0:    return {sadr, 1'b0};
            2'd1:    return madr;
            2'd2:    return rw ? {sadr, 1'b1} : wdata;
            default: return {sadr, 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/i2c_seq_bus.sv
// Single register-access engine: raises m_cs_o on start, holds TXR/CR stable until ack,
// then pulses done with the status and receive registers captured on the ack cycle.
module i2c_seq_bus (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] txr_i,
    input  logic [7:0] cr_i,
    output logic       done_o,
    output logic [7:0] sr_o,
    output logic [7:0] rxr_o,
    output logic       m_cs_o,
    output logic [7:0] m_txr_o,
    output logic [7:0] m_cr_o,
    input  logic       m_ack_i,
    input  logic [7:0] m_sr_i,
    input  logic [7:0] m_rxr_i
);

    logic       cs_q;
    logic       done_q;
    logic [7:0] sr_q;
    logic [7:0] rxr_q;
    logic [7:0] txr_q;
    logic [7:0] cr_q;

    // cs can only rise from a low state, so every access is followed by at least one idle clock.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cs_q   <= 1'b0;
            done_q <= 1'b0;
            sr_q   <= 8'h00;
            rxr_q  <= 8'h00;
            txr_q  <= 8'h00;
            cr_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (cs_q) begin
                if (m_ack_i) begin
                    cs_q   <= 1'b0;
                    done_q <= 1'b1;
                    sr_q   <= m_sr_i;
                    rxr_q  <= m_rxr_i;
                    cr_q   <= 8'h00;
                end
            end else if (start_i) begin
                cs_q  <= 1'b1;
                txr_q <= txr_i;
                cr_q  <= cr_i;
            end
        end
    end

    assign done_o  = done_q;
    assign sr_o    = sr_q;
    assign rxr_o   = rxr_q;
    assign m_cs_o  = cs_q;
    assign m_txr_o = txr_q;
    assign m_cr_o  = cr_q;

endmodule

// File: rtl/i2c_xfer_seq.sv
// Byte-level I2C memory transaction sequencer driving the i2c_master_top register interface:
// one write or random read per request, with NACK, arbitration and TIP-timeout reporting.
module i2c_xfer_seq
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'h00c8,
    parameter int unsigned TIMEOUT  = 20000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rw_i,
    input  logic [6:0]  req_sadr_i,
    input  logic [7:0]  req_madr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [1:0]  rsp_err_o,
    output logic [7:0]  rsp_rdata_o,
    output logic [15:0] m_prer_o,
    output logic [7:0]  m_ctr_o,
    output logic [7:0]  m_txr_o,
    output logic [7:0]  m_cr_o,
    output logic        m_cs_o,
    input  logic        m_ack_i,
    input  logic [7:0]  m_sr_i,
    input  logic [7:0]  m_rxr_i
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    logic [3:0]      state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic            rw_q, rw_d;
    logic [6:0]      sadr_q, sadr_d;
    logic [7:0]      madr_q, madr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            issued_q, issued_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [1:0]      err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [15:0]     prer_q, prer_d;
    logic [7:0]      ctr_q, ctr_d;

    logic       accept, access_st, start, tmo_hit, last_phase;
    logic [7:0] bus_txr, bus_cr, bus_sr, bus_rxr;
    logic       bus_done;
    logic       unused_sr;

    assign accept     = req_valid_i && (state_q == StIdle);
    assign access_st  = state_q inside {StInitPrer, StInitCtr, StIssue, StPoll,
                                        StAbortStop, StAbortPoll};
    assign start      = accept || (access_st && !issued_q);
    assign tmo_hit    = tmo_q >= TmoW'(TIMEOUT);
    assign last_phase = phase_q == (rw_q ? 2'd3 : 2'd2);
    assign unused_sr  = ^{bus_sr[6], bus_sr[4:2], bus_sr[0]};

    // The accept cycle launches phase 0 straight from the request inputs.
    always_comb begin
        bus_txr = phase_txr(rw_q, phase_q, sadr_q, madr_q, wdata_q);
        bus_cr  = 8'h00;
        if (accept) begin
            bus_txr = {req_sadr_i, 1'b0};
            bus_cr  = CrSta | CrWr;
        end else if (state_q == StIssue) begin
            bus_cr = phase_cr(rw_q, phase_q);
        end else if (state_q == StAbortStop) begin
            bus_cr = CrSto;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        rw_d     = rw_q;
        sadr_d   = sadr_q;
        madr_d   = madr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        prer_d   = prer_q;
        ctr_d    = ctr_q;
        issued_d = issued_q;
        tmo_d    = tmo_q;

        if (bus_done) issued_d = 1'b0;
        if (start) issued_d = 1'b1;

        if (start && (accept || state_q == StIssue || state_q == StAbortStop)) begin
            tmo_d = '0;
        end else if (tmo_q != {TmoW{1'b1}}) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            StInitPrer: begin
                if (start) prer_d = PRESCALE;
                if (bus_done) state_d = StInitCtr;
            end
            StInitCtr: begin
                if (start) ctr_d = CtrEn;
                if (bus_done) state_d = StIdle;
            end
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                    phase_d = 2'd0;
                    rw_d    = req_rw_i;
                    sadr_d  = req_sadr_i;
                    madr_d  = req_madr_i;
                    wdata_d = req_wdata_i;
                    err_d   = ErrOk;
                    rdata_d = 8'h00;
                end
            end
            StIssue: begin
                if (bus_done) state_d = StPoll;
            end
            StPoll: begin
                if (bus_done) begin
                    if (!bus_sr[SrTip]) begin
                        state_d = StCheck;
                    end else if (tmo_hit) begin
                        state_d = StResp;
                        err_d   = ErrTmo;
                    end
                end
            end
            StCheck: begin
                if (bus_sr[SrAl]) begin
                    state_d = StResp;
                    err_d   = ErrAl;
                end else if (bus_sr[SrRxAck] && !(rw_q && phase_q == 2'd3)) begin
                    state_d = StAbortStop;
                end else if (last_phase) begin
                    state_d = StResp;
                    err_d   = ErrOk;
                    rdata_d = rw_q ? bus_rxr : 8'h00;
                end else begin
                    state_d = StIssue;
                    phase_d = phase_q + 2'd1;
                end
            end
            StAbortStop: begin
                if (bus_done) state_d = StAbortPoll;
            end
            StAbortPoll: begin
                if (bus_done) begin
                    if (!bus_sr[SrTip]) begin
                        state_d = StResp;
                        err_d   = ErrNack;
                    end else if (tmo_hit) begin
                        state_d = StResp;
                        err_d   = ErrTmo;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StInitPrer;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q  <= StInitPrer;
            phase_q  <= 2'd0;
            rw_q     <= 1'b0;
            sadr_q   <= 7'h00;
            madr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            issued_q <= 1'b0;
            tmo_q    <= '0;
            err_q    <= ErrOk;
            rdata_q  <= 8'h00;
            prer_q   <= 16'h0000;
            ctr_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            rw_q     <= rw_d;
            sadr_q   <= sadr_d;
            madr_q   <= madr_d;
            wdata_q  <= wdata_d;
            issued_q <= issued_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            prer_q   <= prer_d;
            ctr_q    <= ctr_d;
        end
    end

    i2c_seq_bus u_bus (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_i),
        .start_i (start),
        .txr_i   (bus_txr),
        .cr_i    (bus_cr),
        .done_o  (bus_done),
        .sr_o    (bus_sr),
        .rxr_o   (bus_rxr),
        .m_cs_o  (m_cs_o),
        .m_txr_o (m_txr_o),
        .m_cr_o  (m_cr_o),
        .m_ack_i (m_ack_i),
        .m_sr_i  (m_sr_i),
        .m_rxr_i (m_rxr_i)
    );

    assign req_ready_o = state_q == StIdle;
    assign rsp_valid_o = state_q == StResp;
    assign rsp_err_o   = rsp_valid_o ? err_q : ErrOk;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : 8'h00;
    assign m_prer_o    = prer_q;
    assign m_ctr_o     = ctr_q;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Bench for i2c_xfer_seq: a command-level model of the I2C master plus a byte-addressed slave,
// a transaction-level expectation model, and one per-cycle compare process.
module tb_i2c_xfer_seq;

    localparam int unsigned Tmo = 1000;
    localparam logic [6:0]  Slv = 7'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0, req_rw_i = 1'b0;
    logic [6:0]  req_sadr_i = '0;
    logic [7:0]  req_madr_i = '0, req_wdata_i = '0;
    logic        req_ready_o, rsp_valid_o, m_cs_o;
    logic [1:0]  rsp_err_o;
    logic [7:0]  rsp_rdata_o, m_ctr_o, m_txr_o, m_cr_o;
    logic [15:0] m_prer_o;
    logic        m_ack_i = 1'b0;
    logic [7:0]  m_sr_i = '0, m_rxr_i = '0;

    always #5 clk = ~clk;

    i2c_xfer_seq #(.PRESCALE(16'h00c8), .TIMEOUT(Tmo)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_sadr_i(req_sadr_i), .req_madr_i(req_madr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .m_prer_o(m_prer_o), .m_ctr_o(m_ctr_o), .m_txr_o(m_txr_o), .m_cr_o(m_cr_o),
        .m_cs_o(m_cs_o), .m_ack_i(m_ack_i), .m_sr_i(m_sr_i), .m_rxr_i(m_rxr_i)
    );

    typedef struct {logic [15:0] prer; logic [7:0] ctr; logic [7:0] txr; logic [7:0] cr;} acc_t;
    typedef struct {logic [1:0] err; logic [7:0] rdata;} exp_t;

    int checks = 0, failures = 0, cyc = 0, rsp_cnt = 0, t_acc = 0, t_rsp = 0;
    acc_t       acc_log[$];
    logic [7:0] cr_log[$];
    exp_t       exp_q[$];
    logic [7:0] smem[256];
    logic [7:0] exp_mem[256];
    logic [1:0] last_err;
    logic [7:0] last_rdata;

    // Environment knobs and slave state
    bit         stuck = 0, al_mode = 0, addressed = 0, rd_dir = 0, first_wr = 0;
    bit         rxack_r = 0, al_r = 0;
    logic [7:0] ptr = '0, rx_r = '0;
    int         tip_left = 0, dly = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Models one register access of the master at its ack cycle.
    task automatic serve();
        acc_log.push_back('{m_prer_o, m_ctr_o, m_txr_o, m_cr_o});
        if (m_cr_o == 8'h00) begin
            m_sr_i  = {rxack_r, 1'b0, al_r, 3'b000, (stuck || tip_left > 0), 1'b0};
            m_rxr_i = rx_r;
            if (tip_left > 0) tip_left--;
        end else begin
            cr_log.push_back(m_cr_o);
            m_sr_i   = 8'h02;
            tip_left = 2;
            rxack_r  = 0;
            al_r     = 0;
            if (al_mode) begin
                al_r    = 1;
                al_mode = 0;
            end else if (m_cr_o[7]) begin
                addressed = (m_txr_o[7:1] == Slv);
                rd_dir    = m_txr_o[0];
                first_wr  = 1;
                rxack_r   = !addressed;
            end else if (m_cr_o[4]) begin
                if (addressed && !rd_dir) begin
                    if (first_wr) ptr = m_txr_o;
                    else begin
                        smem[ptr] = m_txr_o;
                        ptr++;
                    end
                    first_wr = 0;
                end else rxack_r = 1;
            end else if (m_cr_o[5]) begin
                rx_r = (addressed && rd_dir) ? smem[ptr] : 8'hff;
                ptr++;
            end
            if (m_cr_o[6]) addressed = 0;
        end
    endtask

    // Master responder: variable ack latency, plus stray acks while no access is open.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ack_i = 1'b0;
            if (!rst_n) begin
                dly = 0;
                tip_left = 0;
                addressed = 0;
            end else if (m_cs_o) begin
                if (dly == 0) begin
                    m_ack_i = 1'b1;
                    serve();
                    dly = $urandom_range(0, 2);
                end else dly--;
            end else if (cyc % 3 == 0) begin
                m_ack_i = 1'b1;
                m_sr_i  = 8'hff;
                m_rxr_i = 8'h5a;
            end
        end
    end

    // Compare process: access stability, CR idle value, response shape and contents.
    initial begin
        logic        prev_cs = 0, prev_valid = 0;
        logic [39:0] prev_vals = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_cs_o && prev_cs)
                    chk("access_hold", {m_prer_o, m_ctr_o, m_txr_o, m_cr_o}, prev_vals);
                if (!m_cs_o && prev_cs) chk("cr_idle", m_cr_o, 8'h00);
                if (prev_valid) begin
                    chk("rsp_one_cycle", rsp_valid_o, 1'b0);
                    chk("ready_after_rsp", req_ready_o, 1'b1);
                end
                if (rsp_valid_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp: got err=%0d, expected no response",
                                 rsp_err_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_err", rsp_err_o, e.err);
                        chk("rsp_rdata", rsp_rdata_o, e.rdata);
                    end
                    last_err   = rsp_err_o;
                    last_rdata = rsp_rdata_o;
                    rsp_cnt++;
                end
            end
            prev_cs    = m_cs_o & rst_n;
            prev_valid = rsp_valid_o & rst_n;
            prev_vals  = {m_prer_o, m_ctr_o, m_txr_o, m_cr_o};
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, req_ready_o, 1'b1);
    endtask

    task automatic check_init(input string name);
        chk({name, "_count"}, acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk({name, "_prer"}, acc_log[0].prer, 16'h00c8);
            chk({name, "_cr0"}, acc_log[0].cr, 8'h00);
            chk({name, "_ctr"}, acc_log[1].ctr, 8'h80);
            chk({name, "_cr1"}, acc_log[1].cr, 8'h00);
        end
    endtask

    // Issues one request and checks its command series; the response is checked by the
    // compare process against the model's expectation.
    task automatic do_req(input logic rw, input logic [6:0] sadr, input logic [7:0] madr,
                          input logic [7:0] wdata, output logic [1:0] err_o,
                          output logic [7:0] rd_o);
        exp_t       e;
        logic [7:0] e_crs[$];
        int         n0, n;
        if (al_mode) begin
            e = '{2'b10, 8'h00};
            e_crs = '{8'h90};
        end else if (stuck) begin
            e = '{2'b11, 8'h00};
            e_crs = '{8'h90};
        end else if (sadr != Slv) begin
            e = '{2'b01, 8'h00};
            e_crs = '{8'h90, 8'h40};
        end else if (!rw) begin
            e = '{2'b00, 8'h00};
            e_crs = '{8'h90, 8'h10, 8'h50};
            exp_mem[madr] = wdata;
        end else begin
            e = '{2'b00, exp_mem[madr]};
            e_crs = '{8'h90, 8'h10, 8'h90, 8'h68};
        end
        exp_q.push_back(e);
        cr_log.delete();
        wait_ready("ready_before_req");
        req_valid_i = 1'b1;
        req_rw_i    = rw;
        req_sadr_i  = sadr;
        req_madr_i  = madr;
        req_wdata_i = wdata;
        @(posedge clk);
        #1;
        t_acc = cyc;
        chk("ready_drop", req_ready_o, 1'b0);
        chk("cs_after_accept", m_cs_o, 1'b1);
        // Held-over request with different fields must be ignored while busy.
        req_rw_i   = ~rw;
        req_sadr_i = 7'h3f;
        req_madr_i = 8'hee;
        repeat (4) @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        n0 = rsp_cnt;
        n  = 0;
        while (rsp_cnt == n0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", rsp_cnt - n0, 1);
        t_rsp = cyc;
        chk("cr_count", cr_log.size(), e_crs.size());
        for (int i = 0; i < e_crs.size(); i++)
            if (i < cr_log.size()) chk("cr_seq", cr_log[i], e_crs[i]);
        err_o = last_err;
        rd_o  = last_rdata;
    endtask

    initial begin
        logic [1:0] err;
        logic [7:0] rd;
        int         n, saved;
        for (int i = 0; i < 256; i++) begin
            smem[i]    = 8'h00;
            exp_mem[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready_o, 1'b0);
        chk("rst_cs", m_cs_o, 1'b0);
        chk("rst_prer", m_prer_o, 16'h0000);
        chk("rst_ctr", m_ctr_o, 8'h00);
        chk("rst_txr_cr", {m_txr_o, m_cr_o}, 16'h0000);
        chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 11'h000);
        rst_n = 1'b1;
        wait_ready("init_ready");
        check_init("init");

        do_req(1'b0, 7'h10, 8'h01, 8'ha5, err, rd);
        chk("wr_err_lit", err, 2'b00);
        chk("slave_mem1", smem[1], 8'ha5);

        do_req(1'b1, 7'h10, 8'h01, 8'h00, err, rd);
        chk("rd_data_lit", rd, 8'ha5);

        do_req(1'b0, 7'h10, 8'h07, 8'h3c, err, rd);
        do_req(1'b1, 7'h10, 8'h07, 8'h00, err, rd);
        chk("rd7_data_lit", rd, 8'h3c);

        do_req(1'b0, 7'h55, 8'h02, 8'h11, err, rd);
        chk("nack_err_lit", err, 2'b01);
        do_req(1'b1, 7'h55, 8'h02, 8'h00, err, rd);
        chk("nack_rd_data", rd, 8'h00);

        al_mode = 1;
        do_req(1'b0, 7'h10, 8'h03, 8'h77, err, rd);
        chk("al_err_lit", err, 2'b10);

        stuck = 1;
        do_req(1'b0, 7'h10, 8'h04, 8'h99, err, rd);
        stuck = 0;
        chk("tmo_err_lit", err, 2'b11);
        chk("tmo_latency", (t_rsp - t_acc >= Tmo) && (t_rsp - t_acc <= Tmo + 25), 1'b1);

        // Reset while the phase-2 repeated START of a read is on the bus.
        wait_ready("ready_before_drop");
        cr_log.delete();
        saved       = rsp_cnt;
        req_valid_i = 1'b1;
        req_rw_i    = 1'b1;
        req_sadr_i  = 7'h10;
        req_madr_i  = 8'h01;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!(m_cs_o && m_cr_o == 8'h90 && m_txr_o == 8'h21) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_phase2", m_txr_o, 8'h21);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_cs", m_cs_o, 1'b0);
        chk("rst_mid_ready", req_ready_o, 1'b0);
        acc_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("reinit_ready");
        check_init("reinit");
        repeat (5) @(negedge clk);
        chk("dropped_no_rsp", rsp_cnt, saved);

        do_req(1'b1, 7'h10, 8'h01, 8'h00, err, rd);
        chk("post_reset_rd", rd, 8'ha5);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
